// File: rtl/edge_pipe_ctrl_if.sv
// Handshake bundle between the capture front end, the frame sequencer and
// the edge-detection pipeline.
//   master : capture/host side; drives run control, mode request, frame/data
//            valids and the pipeline output valid; observes sequencer outputs.
//   slave  : the sequencer (edge_pipe_ctrl).
// Signals:
//   iStart, iContinuous, iModeReq[1:0]  run control and requested filter mode
//   iFVAL, iDVAL                        frame / Bayer data valid from capture
//   iOutDVAL                            pipeline output pixel valid
//   oPipeRST_n, oPipeDVAL, oMode[1:0]   flush reset, gated valid, latched mode
//   oBusy, oFrameDone, oFrameErr        status
//   oOutCount[19:0]                     output pixels in current/last frame
interface edge_pipe_ctrl_if;
  logic        iStart;
  logic        iContinuous;
  logic [1:0]  iModeReq;
  logic        iFVAL;
  logic        iDVAL;
  logic        iOutDVAL;
  logic        oPipeRST_n;
  logic        oPipeDVAL;
  logic [1:0]  oMode;
  logic        oBusy;
  logic        oFrameDone;
  logic        oFrameErr;
  logic [19:0] oOutCount;

  modport master (
    output iStart, iContinuous, iModeReq, iFVAL, iDVAL, iOutDVAL,
    input  oPipeRST_n, oPipeDVAL, oMode, oBusy, oFrameDone, oFrameErr, oOutCount
  );

  modport slave (
    input  iStart, iContinuous, iModeReq, iFVAL, iDVAL, iOutDVAL,
    output oPipeRST_n, oPipeDVAL, oMode, oBusy, oFrameDone, oFrameErr, oOutCount
  );
endinterface

// File: rtl/edge_pipe_ctrl.sv
// Frame-level sequencer for the edge-detection pipeline. Flushes the pipeline
// before each frame, admits Bayer data only for whole frames, latches the
// filter mode at start of frame, drains the pipeline after end of frame and
// reports per-frame completion and error.
// Ports:
//   iCLK  pixel clock
//   iRST  asynchronous active-low reset
//   bus   edge_pipe_ctrl_if.slave (run control, valids, mode, status, count)
// Optional build macro EDGE_PIPE_CTRL_STATS_EN adds:
//   oFrameCnt[15:0]  frames completed (wraps)
//   oErrCnt[15:0]    frames completed with error (wraps)
module edge_pipe_ctrl #(
  parameter int unsigned IN_PIXELS     = 1228800,
  parameter int unsigned OUT_PIXELS    = 307200,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic           iCLK,
  input  logic           iRST,
  edge_pipe_ctrl_if.slave bus
`ifdef EDGE_PIPE_CTRL_STATS_EN
  ,
  output logic [15:0]    oFrameCnt,
  output logic [15:0]    oErrCnt
`endif
);

  localparam int IN_W  = 21;
  localparam int OUT_W = 20;
  localparam logic [IN_W-1:0]  IN_PIX     = IN_W'(IN_PIXELS);
  localparam logic [OUT_W-1:0] OUT_PIX    = OUT_W'(OUT_PIXELS);
  localparam logic [15:0]      TMO_LAST   = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FLUSH, ARM, WAIT_SOF, RUN, DRAIN, DONE
  } state_t;

  function automatic logic [IN_W-1:0] sat_inc_in(input logic [IN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [OUT_W-1:0] sat_inc_out(input logic [OUT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic              fval_q, fval_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              in_bad_q, in_bad_d;
  logic              tmo_hit_q, tmo_hit_d;
  logic              fval_rise, fval_fall, frame_err;

  assign fval_rise = bus.iFVAL & ~fval_q;
  assign fval_fall = ~bus.iFVAL & fval_q;
  assign frame_err = (state_q == DONE) &&
                     (in_bad_q || (out_cnt_q != OUT_PIX) || tmo_hit_q);

  always_comb begin
    state_d     = state_q;
    fval_d      = bus.iFVAL;
    mode_d      = mode_q;
    flush_cnt_d = '0;
    tmo_cnt_d   = '0;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    in_bad_d    = in_bad_q;
    tmo_hit_d   = tmo_hit_q;

    if ((state_q == RUN || state_q == DRAIN) && bus.iOutDVAL)
      out_cnt_d = sat_inc_out(out_cnt_q);

    case (state_q)
      IDLE: if (bus.iStart) state_d = FLUSH;
      FLUSH: begin
        if (!bus.iStart) state_d = IDLE;
        else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
          if (flush_cnt_q == FLUSH_LAST) state_d = ARM;
        end
      end
      // Never join a frame already in flight: wait for a quiet FVAL first.
      ARM: begin
        if (!bus.iStart)     state_d = IDLE;
        else if (!bus.iFVAL) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!bus.iStart) state_d = IDLE;
        else if (fval_rise) begin
          mode_d    = bus.iModeReq;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          in_bad_d  = 1'b0;
          tmo_hit_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (bus.iDVAL) in_cnt_d = sat_inc_in(in_cnt_q);
        // Judge the input count including a pixel on the falling cycle itself.
        if (fval_fall) begin
          in_bad_d = (in_cnt_d != IN_PIX);
          state_d  = DRAIN;
        end
      end
      // Reaching the output count wins over a timeout in the same cycle.
      DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (out_cnt_d >= OUT_PIX) state_d = DONE;
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = (bus.iStart && bus.iContinuous) ? FLUSH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= IDLE;
      fval_q      <= 1'b0;
      mode_q      <= 2'b00;
      flush_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_bad_q    <= 1'b0;
      tmo_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      mode_q      <= mode_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_bad_q    <= in_bad_d;
      tmo_hit_q   <= tmo_hit_d;
    end
  end

  // Flush reset releases in the same cycle iStart drops.
  assign bus.oPipeRST_n = ~((state_q == FLUSH) && bus.iStart);
  assign bus.oPipeDVAL  = bus.iDVAL && (state_q == RUN);
  assign bus.oMode      = mode_q;
  assign bus.oBusy      = (state_q != IDLE);
  assign bus.oFrameDone = (state_q == DONE);
  assign bus.oFrameErr  = frame_err;
  assign bus.oOutCount  = out_cnt_q;

`ifdef EDGE_PIPE_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (state_q == DONE) frame_cnt_d = frame_cnt_q + 16'd1;
    if (frame_err)       err_cnt_d   = err_cnt_q + 16'd1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign oFrameCnt = frame_cnt_q;
  assign oErrCnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_edge_pipe_ctrl.sv
// Directed bench for edge_pipe_ctrl with scaled-down frame sizes
// (16 input pixels, 4 output pixels, 4-clock flush, 32-clock drain timeout).
module tb_edge_pipe_ctrl;
  localparam int IN_P  = 16;
  localparam int OUT_P = 4;
  localparam int FLUSH = 4;
  localparam int TMO   = 32;

  logic iCLK = 1'b0;
  logic iRST;
  edge_pipe_ctrl_if bus ();

`ifdef EDGE_PIPE_CTRL_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  edge_pipe_ctrl #(
    .IN_PIXELS(IN_P), .OUT_PIXELS(OUT_P),
    .FLUSH_CYCLES(FLUSH), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
`ifdef EDGE_PIPE_CTRL_STATS_EN
    ,
    .oFrameCnt(frame_cnt),
    .oErrCnt  (err_cnt)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0] mode;
    int         n_dval;
    int         n_out_run;
    int         n_out_drn;
    logic       exp_err;
    int         exp_out;
    int         exp_drain;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   stat_frames = 0;
  int   stat_errs   = 0;
  logic last_err;
  logic [19:0] last_out;
  logic [1:0]  last_mode;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (bus.oFrameDone) begin
      chk("done_single_pulse", {31'd0, prev_done}, 0);
      done_cnt++;
      done_cyc  = cyc;
      last_err  = bus.oFrameErr;
      last_out  = bus.oOutCount;
      last_mode = bus.oMode;
      stat_frames++;
      if (bus.oFrameErr) stat_errs++;
    end
    if (bus.oFrameErr) chk("err_with_done", {31'd0, bus.oFrameDone}, 1);
    prev_done = bus.oFrameDone;
  end

  // Expects the DUT waiting for start of frame with iFVAL low.
  task automatic run_frame(input vec_t v, input logic [1:0] new_mode, input bit drop_start);
    int d0, pix_bad, fall_cyc, k;
    d0 = done_cnt;
    pix_bad = 0;
    bus.iFVAL = 1'b1;
    tick();
    for (int i = 0; i < v.n_dval; i++) begin
      bus.iDVAL    = 1'b1;
      bus.iOutDVAL = (i < v.n_out_run);
      if (i == v.n_dval / 2) begin
        bus.iModeReq = new_mode;
        if (drop_start) bus.iStart = 1'b0;
      end
      #1;
      if (i == 0) chk("first_pix_gated", {31'd0, bus.oPipeDVAL}, 1);
      else if (bus.oPipeDVAL !== 1'b1) pix_bad++;
      tick();
    end
    bus.iDVAL = 1'b0;
    bus.iOutDVAL = 1'b0;
    bus.iFVAL = 1'b0;
    if (drop_start) bus.iStart = 1'b0;
    tick();
    fall_cyc = cyc;
    if (v.n_dval > 1) chk("pix_gate_run", pix_bad, 0);
    for (int j = 0; j < v.n_out_drn; j++) begin
      bus.iOutDVAL = 1'b1;
      tick();
    end
    bus.iOutDVAL = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      tick();
      k++;
    end
    chk("frame_done_seen", done_cnt - d0, 1);
    chk("frame_err", {31'd0, last_err}, {31'd0, v.exp_err});
    chk("out_count", {12'd0, last_out}, v.exp_out);
    chk("latched_mode", {30'd0, last_mode}, {30'd0, v.mode});
    chk("drain_len", done_cyc - fall_cyc, v.exp_drain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  vec_t vecs[10];
  vec_t good;
  int   cnt;

  initial begin
    //           mode   dval run drn err out drain
    vecs[0] = '{2'b00, 16,  0,  4,  1'b0, 4,  4};
    vecs[1] = '{2'b01, 16,  2,  2,  1'b0, 4,  2};
    vecs[2] = '{2'b10, 10,  0,  4,  1'b1, 4,  4};
    vecs[3] = '{2'b00, 17,  0,  4,  1'b1, 4,  4};
    vecs[4] = '{2'b01, 16,  0,  3,  1'b1, 3,  32};
    vecs[5] = '{2'b10,  0,  0,  4,  1'b1, 4,  4};
    vecs[6] = '{2'b00, 16,  0,  0,  1'b1, 0,  32};
    vecs[7] = '{2'b01, 16,  0,  5,  1'b0, 4,  4};
    vecs[8] = '{2'b10, 16,  4,  0,  1'b0, 4,  1};
    vecs[9] = '{2'b00, 16,  5,  0,  1'b1, 5,  1};
    good    = '{2'b01, 16,  0,  4,  1'b0, 4,  4};

    iRST = 1'b0;
    bus.iStart = 1'b0; bus.iContinuous = 1'b0; bus.iModeReq = 2'b00;
    bus.iFVAL = 1'b0; bus.iDVAL = 1'b0; bus.iOutDVAL = 1'b0;
    #12;
    chk("rst_pipe_rst_n", {31'd0, bus.oPipeRST_n}, 1);
    chk("rst_pipe_dval", {31'd0, bus.oPipeDVAL}, 0);
    chk("rst_mode", {30'd0, bus.oMode}, 0);
    chk("rst_busy", {31'd0, bus.oBusy}, 0);
    chk("rst_done", {31'd0, bus.oFrameDone}, 0);
    chk("rst_err", {31'd0, bus.oFrameErr}, 0);
    chk("rst_outcount", {12'd0, bus.oOutCount}, 0);
    iRST = 1'b1;
    tick(); tick();

    // Flush pulse length
    bus.iStart = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.oPipeRST_n == 1'b0) cnt++;
      if (i == 0) chk("busy_in_flush", {31'd0, bus.oBusy}, 1);
    end
    chk("flush_len", cnt, FLUSH);
    bus.iStart = 1'b0;
    tick();
    chk("stop_idle", {31'd0, bus.oBusy}, 0);

    // Abort while flushing
    bus.iStart = 1'b1;
    tick(); tick();
    chk("flush_active", {31'd0, bus.oPipeRST_n}, 0);
    bus.iStart = 1'b0;
    #1;
    chk("flush_abort_rstn", {31'd0, bus.oPipeRST_n}, 1);
    tick();
    chk("flush_abort_idle", {31'd0, bus.oBusy}, 0);

    // Abort while armed behind a running frame
    bus.iFVAL = 1'b1;
    bus.iStart = 1'b1;
    repeat (8) tick();
    chk("arm_hold_busy", {31'd0, bus.oBusy}, 1);
    bus.iStart = 1'b0;
    tick();
    chk("arm_abort_idle", {31'd0, bus.oBusy}, 0);
    bus.iFVAL = 1'b0;
    tick();

    // Abort in WAIT_SOF, coincident with a frame start
    bus.iStart = 1'b1;
    repeat (8) tick();
    bus.iStart = 1'b0;
    bus.iFVAL = 1'b1;
    tick();
    chk("sof_abort_idle", {31'd0, bus.oBusy}, 0);
    bus.iFVAL = 1'b0;
    tick();

    // Single-frame table
    for (int r = 0; r < 10; r++) begin
      bus.iModeReq = vecs[r].mode;
      bus.iContinuous = 1'b0;
      bus.iStart = 1'b1;
      repeat (8) tick();
      run_frame(vecs[r], (vecs[r].mode == 2'b00) ? 2'b10 : 2'b00, 1'b1);
      chk("idle_after_frame", {31'd0, bus.oBusy}, 0);
      tick();
      chk("outcount_hold_idle", {12'd0, bus.oOutCount}, vecs[r].exp_out);
    end

    // Start requested mid-frame: must wait for the next frame
    bus.iModeReq = 2'b01;
    bus.iFVAL = 1'b1;
    bus.iDVAL = 1'b1;
    tick();
    bus.iStart = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.oPipeDVAL !== 1'b0) cnt++;
    end
    chk("midframe_no_join", cnt, 0);
    chk("midframe_armed", {31'd0, bus.oBusy}, 1);
    bus.iFVAL = 1'b0;
    bus.iDVAL = 1'b0;
    repeat (3) tick();
    run_frame(good, 2'b01, 1'b1);

    // Continuous mode with mode change mid-frame
    bus.iModeReq = 2'b00;
    bus.iContinuous = 1'b1;
    bus.iStart = 1'b1;
    repeat (8) tick();
    good.mode = 2'b00;
    run_frame(good, 2'b10, 1'b0);
    chk("cont_rearm_busy", {31'd0, bus.oBusy}, 1);
    chk("cont_rearm_flush", {31'd0, bus.oPipeRST_n}, 0);
    repeat (8) tick();
    bus.iContinuous = 1'b0;
    good.mode = 2'b10;
    run_frame(good, 2'b00, 1'b1);
    chk("cont_end_idle", {31'd0, bus.oBusy}, 0);

`ifdef EDGE_PIPE_CTRL_STATS_EN
    chk("stat_frames", {16'd0, frame_cnt}, stat_frames);
    chk("stat_errs", {16'd0, err_cnt}, stat_errs);
`endif

    // Asynchronous reset while draining
    bus.iModeReq = 2'b01;
    bus.iStart = 1'b1;
    repeat (8) tick();
    bus.iFVAL = 1'b1;
    tick();
    for (int i = 0; i < IN_P; i++) begin
      bus.iDVAL = 1'b1;
      bus.iOutDVAL = (i < 2);
      tick();
    end
    bus.iDVAL = 1'b0;
    bus.iOutDVAL = 1'b0;
    bus.iFVAL = 1'b0;
    tick();
    tick();
    chk("drain_busy", {31'd0, bus.oBusy}, 1);
    chk("drain_outcount", {12'd0, bus.oOutCount}, 2);
    chk("drain_mode", {30'd0, bus.oMode}, 1);
    #2;
    iRST = 1'b0;
    stat_frames = 0;
    stat_errs = 0;
    #1;
    chk("arst_busy", {31'd0, bus.oBusy}, 0);
    chk("arst_mode", {30'd0, bus.oMode}, 0);
    chk("arst_outcount", {12'd0, bus.oOutCount}, 0);
    chk("arst_done", {31'd0, bus.oFrameDone}, 0);
    chk("arst_err", {31'd0, bus.oFrameErr}, 0);
    chk("arst_pipe_rst_n", {31'd0, bus.oPipeRST_n}, 1);
    chk("arst_pipe_dval", {31'd0, bus.oPipeDVAL}, 0);
`ifdef EDGE_PIPE_CTRL_STATS_EN
    chk("arst_stat_frames", {16'd0, frame_cnt}, 0);
`endif
    #2;
    iRST = 1'b1;
    #1;
    chk("post_rst_idle", {31'd0, bus.oBusy}, 0);
    tick();
    chk("restart_via_flush", {31'd0, bus.oPipeRST_n}, 0);
    bus.iStart = 1'b0;
    tick(); tick();
    chk("final_idle", {31'd0, bus.oBusy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/edge_pipe_ctrl.md
Name: edge_pipe_ctrl

Overview:
Frame-level sequencer for the edge-detection pipeline. Sits between CCD_Capture and the pipeline. It flushes the pipeline before each frame and gates the Bayer data-valid so only whole frames enter. It latches the filter mode at frame start, drains the pipeline after frame end, and reports per-frame completion and errors.

Parameters:
IN_PIXELS, 1228800, Bayer pixels per complete input frame (1280x960).
OUT_PIXELS, 307200, pipeline output pixels expected per frame (640x480).
FLUSH_CYCLES, 4, length of pipeline flush-reset pulse in clocks (1..15).
DRAIN_TIMEOUT, 4096, max clocks in DRAIN waiting for output count (1..65535).

Ports:
iCLK  in  1  pixel clock
iRST  in  1  asynchronous, active-low reset
iStart  in  1  level; 1 = run, 0 = stop after current frame
iContinuous  in  1  1 = re-arm after each frame, 0 = single frame then IDLE
iModeReq  in  2  requested filter mode (00 combined, 01 Gx, 10 Gy)
iFVAL  in  1  frame valid from CCD_Capture
iDVAL  in  1  Bayer data valid from CCD_Capture
iOutDVAL  in  1  pipeline output valid
oPipeRST_n  out  1  active-low flush reset to pipeline (combine with iRST externally)
oPipeDVAL  out  1  gated data valid to pipeline
oMode  out  2  latched mode to pipeline
oBusy  out  1  high in any state other than IDLE
oFrameDone  out  1  1-clock pulse at frame completion
oFrameErr  out  1  1-clock pulse, coincident with oFrameDone, if frame was bad
oOutCount  out  20  output pixels counted in current/last frame

Behaviour:
- Reset values: state IDLE, oPipeRST_n=1, oPipeDVAL=0, oMode=00, oBusy=0, oFrameDone=0, oFrameErr=0, oOutCount=0, all internal counters 0.
- States:
  - IDLE: go to FLUSH when iStart=1.
  - FLUSH: oPipeRST_n=0 for exactly FLUSH_CYCLES clocks, then ARM.
  - ARM: wait for iFVAL=0, so a frame already in progress is never joined; then WAIT_SOF.
  - WAIT_SOF: on iFVAL 0->1 edge, latch oMode<=iModeReq, clear input and output counters, go to RUN.
  - RUN: oPipeDVAL=iDVAL, combinational AND with (state==RUN). Input counter increments per iDVAL. On iFVAL 1->0, go to DRAIN.
  - DRAIN: oPipeDVAL=0. Exit when the output counter reaches OUT_PIXELS, or when the timeout counter reaches DRAIN_TIMEOUT, whichever comes first; then DONE.
  - DONE: one clock. Asserts oFrameDone. Next state is FLUSH if iStart=1 and iContinuous=1, else IDLE.
- oOutCount increments on iOutDVAL in RUN and DRAIN. It saturates at 2^20-1 and holds its value in IDLE.
- oFrameErr=1 in DONE if any of these holds:
  - input count != IN_PIXELS at the iFVAL fall;
  - output count != OUT_PIXELS;
  - the DRAIN timeout fired.
- iModeReq changes outside the WAIT_SOF edge have no effect. oMode is stable for a whole frame.
- iStart falling in FLUSH, ARM or WAIT_SOF: go to IDLE next clock. In FLUSH, oPipeRST_n returns to 1 immediately.
- iStart falling in RUN or DRAIN: the frame completes normally; DONE then goes to IDLE.
- iFVAL edge detection uses a 1-clock registered copy of iFVAL.
- If iFVAL rises and falls in the same RUN frame with zero iDVAL, the frame is still counted and flagged as an error.
- Asynchronous iRST mid-frame returns everything to reset values. The next frame starts only via IDLE->FLUSH.

Optional Feature:
EDGE_PIPE_CTRL_STATS_EN: when defined, adds two output ports:
- oFrameCnt [15:0]: increments in every DONE.
- oErrCnt [15:0]: increments in DONE when oFrameErr=1.
Both wrap modulo 2^16 and reset to 0. When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
1. iStart=1, iContinuous=0, one correct frame of 1228800 iDVAL with 307200 iOutDVAL -> oPipeRST_n low exactly 4 clocks, oFrameDone pulse 1 clock, oFrameErr=0, oOutCount=307200, then IDLE with oBusy=0.
2. Assert iStart while iFVAL=1 mid-frame -> oPipeDVAL stays 0 until the next iFVAL rise; first gated pixel is the first pixel of the new frame.
3. Frame of 1000 pixels only -> oFrameErr=1 with oFrameDone.
4. Output stops at 307199 pixels -> DRAIN exits after 4096 clocks, oFrameErr=1.
5. iModeReq toggles 00->10 mid-RUN, continuous mode -> oMode=00 for the current frame and 10 from the next iFVAL rise.
6. iStart dropped mid-RUN -> frame finishes with oFrameDone, then IDLE. Separately, async iRST in DRAIN -> all outputs reset immediately.
